// File: rtl/dds_lfm_pkg.sv
// Shared encodings for the LFM sweep sequencer: sweep modes, FSM states, default FTW width.
`default_nettype none

package dds_lfm_pkg;

  localparam int N_PHASE_DEF = 32;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_TRI  = 2'd2;
  localparam logic [1:0] MODE_HOLD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RAMP_A = 2'd1,
    ST_RAMP_B = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/lfm_sweep_ctrl.sv
// Sweep sequencer for the DDS chirp stage: emits one FTW per clock for up/down/triangle/hold
// sweeps with burst repeat and abort.
`default_nettype none

module lfm_sweep_ctrl
  import dds_lfm_pkg::*;
#(
  parameter int N_PHASE = N_PHASE_DEF,
  parameter int CNT_W   = 24,
  parameter int REP_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [N_PHASE-1:0] ftw_start,
  input  logic [N_PHASE-1:0] ftw_delta,
  input  logic [CNT_W-1:0]   n_samples,
  input  logic [REP_W-1:0]   n_repeat,
  output logic [N_PHASE-1:0] ftw,
  output logic               ftw_valid,
  output logic               phase_clr,
  output logic               busy,
  output logic               done
);

  state_e             state;
  logic [1:0]         mode_r;
  logic [N_PHASE-1:0] ftw_start_r;
  logic [N_PHASE-1:0] delta_r;
  logic [CNT_W-1:0]   n_r;
  logic [REP_W-1:0]   rep_r;
  logic [CNT_W-1:0]   seg_cnt;
  logic [REP_W-1:0]   rep_cnt;

  logic               seg_last;
  logic               step_down;
  logic [REP_W-1:0]   rep_next;

  assign seg_last  = (seg_cnt == n_r - CNT_W'(1));
  // The falling half of a triangle steps down exactly like a down sweep.
  assign step_down = (state == ST_RAMP_B) || (mode_r == MODE_DOWN);
  assign rep_next  = rep_cnt + REP_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      mode_r      <= '0;
      ftw_start_r <= '0;
      delta_r     <= '0;
      n_r         <= '0;
      rep_r       <= '0;
      seg_cnt     <= '0;
      rep_cnt     <= '0;
      ftw         <= '0;
      ftw_valid   <= 1'b0;
      phase_clr   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done      <= 1'b0;
      phase_clr <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            mode_r      <= mode;
            ftw_start_r <= ftw_start;
            delta_r     <= (mode == MODE_HOLD) ? '0 : ftw_delta;
            n_r         <= (n_samples == '0) ? CNT_W'(1) : n_samples;
            rep_r       <= n_repeat;
            seg_cnt     <= '0;
            rep_cnt     <= '0;
            ftw         <= ftw_start;
            ftw_valid   <= 1'b1;
            phase_clr   <= 1'b1;
            busy        <= 1'b1;
            state       <= ST_RAMP_A;
          end
        end
        ST_RAMP_A, ST_RAMP_B: begin
          if (abort) begin
            state     <= ST_IDLE;
            ftw_valid <= 1'b0;
            busy      <= 1'b0;
          end else if (!seg_last) begin
            seg_cnt <= seg_cnt + CNT_W'(1);
            ftw     <= step_down ? (ftw - delta_r) : (ftw + delta_r);
          end else if (state == ST_RAMP_A && mode_r == MODE_TRI) begin
            // Peak sample is repeated as the first sample of the falling segment.
            state   <= ST_RAMP_B;
            seg_cnt <= '0;
          end else if (rep_r != '0 && rep_next == rep_r) begin
            state     <= ST_IDLE;
            ftw_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            rep_cnt   <= rep_next;
            seg_cnt   <= '0;
            ftw       <= ftw_start_r;
            phase_clr <= 1'b1;
            state     <= ST_RAMP_A;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
